aes_trace_sequencer: RTL

//  Autonomous stimulus/capture controller upstream of the AES core in the power-analysis build (no I/O).

---
 rtl/aes_seq_pkg.sv | 30 +++
 rtl/aes_xorshift128.sv | 28 ++
 rtl/aes_trace_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and the xorshift128 step for the AES trace sequencer.
// The sequencer top (optional macro AES_SEQ_FVR_EN) imports this package.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERR
    } seq_state_t;

    localparam int GEN_STEPS     = 4;
    localparam int BUSY_WAIT_MAX = 4;

    localparam logic [1:0] GEN_LAST = 2'(GEN_STEPS - 1);
    localparam logic [1:0] BW_LAST  = 2'(BUSY_WAIT_MAX - 1);

    // State packing is {x,y,z,w}, x in the top word.
    function automatic logic [127:0] xorshift128_step(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        {x, y, z, w} = s;
        t = x ^ (x << 11);
        return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
    endfunction

endpackage

// File: rtl/aes_xorshift128.sv
// Marsaglia xorshift128 PRNG; o_w_nxt is the w word produced by the step
// taken on the coming edge when i_step is high.
module aes_xorshift128
    import aes_seq_pkg::*;
#(
    parameter logic [127:0] SEED = 128'h075BCD15_159A55E5_1F123BB5_05491333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_step,
    output logic [31:0] o_w_nxt
);

    logic [127:0] r_s;
    logic [127:0] w_s_nxt;

    assign w_s_nxt = xorshift128_step(r_s);
    assign o_w_nxt = w_s_nxt[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= SEED;
        end else if (i_step) begin
            r_s <= w_s_nxt;
        end
    end

endmodule

// File: rtl/aes_trace_sequencer.sv
// Autonomous plaintext generator / ciphertext capture for AES power traces.
// Define AES_SEQ_FVR_EN for fixed-vs-random interleave and fvr_class_o.
module aes_trace_sequencer
    import aes_seq_pkg::*;
#(
    parameter logic [31:0]  NUM_TRACES = 32'd1000,
    parameter logic [15:0]  GAP_CYCLES = 16'd64,
    parameter logic [15:0]  TIMEOUT    = 16'd255,
    parameter logic [127:0] SEED       = 128'h075BCD15_159A55E5_1F123BB5_05491333,
    parameter logic         DEC        = 1'b0,
    parameter logic [127:0] FIXED_PT   = 128'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         stop_i,
    output logic         aes_load_o,
    output logic [127:0] aes_data_o,
    output logic         aes_dec_o,
    input  logic         aes_busy_i,
    input  logic [127:0] aes_data_i,
    output logic         trigger_o,
    output logic         ct_valid_o,
    output logic [127:0] last_ct_o,
    output logic [31:0]  trace_cnt_o,
    output logic         running_o,
    output logic         done_o,
    output logic         err_o
`ifdef AES_SEQ_FVR_EN
   ,output logic         fvr_class_o
`endif
);

    seq_state_t   r_state;
    seq_state_t   w_state_nxt;
    logic [1:0]   r_gen;
    logic [1:0]   r_bw;
    logic [15:0]  r_to;
    logic [15:0]  r_gap;
    logic         r_stop;
    logic [31:0]  r_cnt;
    logic [95:0]  r_acc;
    logic [127:0] r_pt;
    logic [127:0] r_ct;

    logic         w_step;
    logic         w_to_hit;
    logic         w_gap_end;
    logic         w_finish;
    logic         w_running;
    logic         w_fixed;
    logic [31:0]  w_rnd;
    logic [127:0] w_pt;

    aes_xorshift128 #(
        .SEED(SEED)
    ) u_prng (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_step),
        .o_w_nxt(w_rnd)
    );

`ifdef AES_SEQ_FVR_EN
    logic r_fvr;
    assign w_fixed     = r_cnt[0];
    assign fvr_class_o = r_fvr;
`else
    assign w_fixed = 1'b0;
`endif

    assign w_step    = (r_state == S_GEN);
    assign w_pt      = w_fixed ? FIXED_PT : {r_acc, w_rnd};
    assign w_to_hit  = (r_to == TIMEOUT - 16'd1);
    assign w_gap_end = (r_gap == GAP_CYCLES - 16'd1);
    assign w_finish  = r_stop ||
                       ((NUM_TRACES != 32'd0) && (r_cnt == NUM_TRACES));
    assign w_running = !((r_state == S_IDLE) || (r_state == S_ERR));

    assign aes_data_o  = r_pt;
    assign aes_dec_o   = DEC;
    assign last_ct_o   = r_ct;
    assign trace_cnt_o = r_cnt;
    assign running_o   = w_running;

    always_comb begin
        w_state_nxt = r_state;
        aes_load_o  = 1'b0;
        trigger_o   = 1'b0;
        ct_valid_o  = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_GEN;
            end
            S_GEN: begin
                if (r_gen == GEN_LAST) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                aes_load_o  = 1'b1;
                trigger_o   = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                trigger_o = 1'b1;
                if (aes_busy_i)                   w_state_nxt = S_WAIT_DONE;
                else if (r_bw == BW_LAST || w_to_hit) w_state_nxt = S_ERR;
            end
            S_WAIT_DONE: begin
                trigger_o = 1'b1;
                if (!aes_busy_i)   w_state_nxt = S_GAP;
                else if (w_to_hit) w_state_nxt = S_ERR;
            end
            S_GAP: begin
                ct_valid_o = (r_gap == 16'd0);
                if (w_gap_end) w_state_nxt = w_finish ? S_DONE : S_GEN;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                err_o = 1'b1;
                if (start_i) w_state_nxt = S_GEN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gen   <= '0;
            r_bw    <= '0;
            r_to    <= '0;
            r_gap   <= '0;
            r_stop  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pt    <= '0;
            r_ct    <= '0;
`ifdef AES_SEQ_FVR_EN
            r_fvr   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            // A stop only takes effect at the end of the current gap.
            if (w_running && stop_i) r_stop <= 1'b1;
            unique case (r_state)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        r_cnt  <= '0;
                        r_stop <= 1'b0;
                        r_gen  <= '0;
                    end
                end
                S_GEN: begin
                    r_gen <= r_gen + 2'd1;
                    r_acc <= {r_acc[63:0], w_rnd};
                    if (r_gen == GEN_LAST) begin
                        r_pt  <= w_pt;
`ifdef AES_SEQ_FVR_EN
                        r_fvr <= w_fixed;
`endif
                    end
                end
                S_LOAD: begin
                    r_to <= '0;
                    r_bw <= '0;
                end
                S_WAIT_BUSY: begin
                    r_to <= r_to + 16'd1;
                    r_bw <= r_bw + 2'd1;
                end
                S_WAIT_DONE: begin
                    r_to <= r_to + 16'd1;
                    if (!aes_busy_i) begin
                        r_ct  <= aes_data_i;
                        r_gap <= '0;
                        if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
